// File: rtl/mem_data_initiator_pkg.sv
// Shared types and helpers for the LSU-side data-memory initiator.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  // Latched request attributes that outlive the accept cycle
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
  } op_t;

  // Length code ordered {m0,m1,m2,m3}
  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_initiator_if.sv
// LSU request/response channel plus data-memory read/write port.
interface mem_data_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  pLsu_pReq_bValid;
  logic                  pLsu_pReq_bReady;
  logic                  pLsu_pReq_bWrEn;
  logic [1:0]            pLsu_pReq_bSize;
  logic                  pLsu_pReq_bUnsigned;
  logic [ADDR_WIDTH-1:0] pLsu_pReq_bAddr;
  logic [DATA_WIDTH-1:0] pLsu_pReq_bData;
  logic                  pLsu_pResp_bValid;
  logic                  pLsu_pResp_bReady;
  logic [DATA_WIDTH-1:0] pLsu_pResp_bData;
  logic                  pLsu_pResp_bErr;
  logic                  pMemData_pRd_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
  logic                  pMemData_pWr_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
  logic                  pMemData_pWr_bMask_0;
  logic                  pMemData_pWr_bMask_1;
  logic                  pMemData_pWr_bMask_2;
  logic                  pMemData_pWr_bMask_3;

  // Initiator view: the block that turns LSU requests into memory accesses
  modport master (
    input  pLsu_pReq_bValid, pLsu_pReq_bWrEn, pLsu_pReq_bSize, pLsu_pReq_bUnsigned,
    input  pLsu_pReq_bAddr, pLsu_pReq_bData, pLsu_pResp_bReady, pMemData_pRd_bData,
    output pLsu_pReq_bReady, pLsu_pResp_bValid, pLsu_pResp_bData, pLsu_pResp_bErr,
    output pMemData_pRd_bEn, pMemData_pRd_bAddr,
    output pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
    output pMemData_pWr_bMask_0, pMemData_pWr_bMask_1, pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );

  modport slave (
    output pLsu_pReq_bValid, pLsu_pReq_bWrEn, pLsu_pReq_bSize, pLsu_pReq_bUnsigned,
    output pLsu_pReq_bAddr, pLsu_pReq_bData, pLsu_pResp_bReady, pMemData_pRd_bData,
    input  pLsu_pReq_bReady, pLsu_pResp_bValid, pLsu_pResp_bData, pLsu_pResp_bErr,
    input  pMemData_pRd_bEn, pMemData_pRd_bAddr,
    input  pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
    input  pMemData_pWr_bMask_0, pMemData_pWr_bMask_1, pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );
endinterface

// File: rtl/mem_data_initiator_load_extend.sv
// Load result formatting: pick the low byte/half/word and sign- or zero-extend it.
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = rdata;
    case (size)
      SZ_B:    result = {{(DATA_WIDTH-8){~uns & rdata[7]}}, rdata[7:0]};
      SZ_H:    result = {{(DATA_WIDTH-16){~uns & rdata[15]}}, rdata[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_data_initiator.sv
// Single-outstanding load/store initiator between the LSU and the data-memory responder.
module mem_data_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RD_LATENCY  = 1,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  mem_data_initiator_if.master bus
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e                state;
  op_t                   op;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [3:0]            mask_q;
  logic [CW-1:0]         cnt;
  logic                  err_q, req_rdy_q, resp_vld_q, rd_en_q, wr_en_q;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic                  acc, bad_req;

  assign acc     = req_rdy_q & bus.pLsu_pReq_bValid;
  assign bad_req = (bus.pLsu_pReq_bSize == SZ_X) ||
                   (ALIGN_CHECK && misaligned(bus.pLsu_pReq_bSize, bus.pLsu_pReq_bAddr[1:0]));

  mem_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .rdata  (bus.pMemData_pRd_bData),
    .size   (op.size),
    .uns    (op.uns),
    .result (ld_ext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op         <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      res_q      <= '0;
      mask_q     <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      req_rdy_q  <= 1'b1;
      resp_vld_q <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (acc) begin
          op.size   <= bus.pLsu_pReq_bSize;
          op.uns    <= bus.pLsu_pReq_bUnsigned;
          addr_q    <= bus.pLsu_pReq_bAddr;
          wdata_q   <= bus.pLsu_pReq_bData;
          mask_q    <= size_to_mask(bus.pLsu_pReq_bSize);
          res_q     <= '0;
          req_rdy_q <= 1'b0;
          err_q     <= bad_req;
          // Rejected requests skip memory entirely and answer on the next cycle
          if (bad_req) begin
            state      <= ST_RESP;
            resp_vld_q <= 1'b1;
          end else if (bus.pLsu_pReq_bWrEn) begin
            state   <= ST_WR;
            wr_en_q <= 1'b1;
          end else begin
            state   <= ST_RD;
            rd_en_q <= 1'b1;
            cnt     <= CW'(RD_LATENCY - 1);
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            res_q      <= ld_ext;
            rd_en_q    <= 1'b0;
            resp_vld_q <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR: begin
          wr_en_q    <= 1'b0;
          resp_vld_q <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: if (bus.pLsu_pResp_bReady) begin
          resp_vld_q <= 1'b0;
          req_rdy_q  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pLsu_pReq_bReady     = req_rdy_q;
  assign bus.pLsu_pResp_bValid    = resp_vld_q;
  assign bus.pLsu_pResp_bData     = res_q;
  assign bus.pLsu_pResp_bErr      = err_q;
  assign bus.pMemData_pRd_bEn     = rd_en_q;
  assign bus.pMemData_pRd_bAddr   = addr_q;
  assign bus.pMemData_pWr_bEn     = wr_en_q;
  assign bus.pMemData_pWr_bAddr   = addr_q;
  assign bus.pMemData_pWr_bData   = wdata_q;
  assign bus.pMemData_pWr_bMask_0 = mask_q[3];
  assign bus.pMemData_pWr_bMask_1 = mask_q[2];
  assign bus.pMemData_pWr_bMask_2 = mask_q[1];
  assign bus.pMemData_pWr_bMask_3 = mask_q[0];

endmodule

// File: tb/tb_mem_data_initiator.sv
// Directed bench: timeline model of each request checked every cycle, plus literal expectations.
module tb_mem_data_initiator;

  localparam int LAT = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_data_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_data_initiator #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(LAT), .ALIGN_CHECK(1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem_word = 32'h0;
  assign bus.pMemData_pRd_bData = bus.pMemData_pRd_bEn ? mem_word : 32'hA5A5_A5A5;

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;
  always @(posedge clock) pcnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural expectations straight from the load/size rules
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz, input logic u);
    int v;
    case (sz)
      2'd0: begin v = int'(w & 32'hFF);   if (!u && v >= 128)   v -= 256;   end
      2'd1: begin v = int'(w & 32'hFFFF); if (!u && v >= 32768) v -= 65536; end
      default: v = int'(w);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 4'b0001;
    if (sz == 2'd1) return 4'b0011;
    return 4'b1111;
  endfunction

  // Timeline model: negedge indices at which each output is due
  int ecnt = 0;
  bit pend = 0;
  int v_at, rd_lo, rd_hi, wr_at;
  logic [31:0] m_data, m_addr, m_wdata;
  logic m_err;
  logic [3:0] m_mask;
  int rd_seen, wr_seen;
  logic [3:0] last_mask;
  logic [31:0] last_wdata;
  bit exp_rv, exp_rd, exp_wr;

  always @(negedge clock) begin
    ecnt++;
    if (!reset) begin
      pend = 0;
    end else begin
      exp_rv = pend && ecnt >= v_at;
      exp_rd = pend && ecnt >= rd_lo && ecnt <= rd_hi;
      exp_wr = pend && ecnt == wr_at;
      chk("req_ready", 32'(bus.pLsu_pReq_bReady), 32'(!pend));
      chk("resp_valid", 32'(bus.pLsu_pResp_bValid), 32'(exp_rv));
      chk("rd_en", 32'(bus.pMemData_pRd_bEn), 32'(exp_rd));
      chk("wr_en", 32'(bus.pMemData_pWr_bEn), 32'(exp_wr));
      if (exp_rd) chk("rd_addr", bus.pMemData_pRd_bAddr, m_addr);
      if (exp_wr) begin
        chk("wr_addr", bus.pMemData_pWr_bAddr, m_addr);
        chk("wr_data", bus.pMemData_pWr_bData, m_wdata);
        chk("wr_mask", 32'({bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
                            bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3}), 32'(m_mask));
      end
      if (exp_rv) begin
        chk("resp_data", bus.pLsu_pResp_bData, m_data);
        chk("resp_err", 32'(bus.pLsu_pResp_bErr), 32'(m_err));
      end
      if (bus.pMemData_pRd_bEn) rd_seen++;
      if (bus.pMemData_pWr_bEn) begin
        wr_seen++;
        last_mask  = {bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
                      bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3};
        last_wdata = bus.pMemData_pWr_bData;
      end
      // Decide what the coming rising edge does
      if (exp_rv && bus.pLsu_pResp_bReady) begin
        pend = 0;
      end else if (!pend && bus.pLsu_pReq_bValid) begin
        pend    = 1;
        m_addr  = bus.pLsu_pReq_bAddr;
        m_wdata = bus.pLsu_pReq_bData;
        m_mask  = model_mask(bus.pLsu_pReq_bSize);
        m_err   = (bus.pLsu_pReq_bSize == 2'd3) ||
                  (bus.pLsu_pReq_bSize == 2'd1 && bus.pLsu_pReq_bAddr[0]) ||
                  (bus.pLsu_pReq_bSize == 2'd2 && bus.pLsu_pReq_bAddr[1:0] != 2'd0);
        rd_lo = 1; rd_hi = 0; wr_at = 0;
        if (m_err) begin
          m_data = 32'h0; v_at = ecnt + 1;
        end else if (bus.pLsu_pReq_bWrEn) begin
          m_data = 32'h0; wr_at = ecnt + 1; v_at = ecnt + 2;
        end else begin
          m_data = model_load(mem_word, bus.pLsu_pReq_bSize, bus.pLsu_pReq_bUnsigned);
          rd_lo = ecnt + 1; rd_hi = ecnt + LAT; v_at = ecnt + LAT + 1;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] mw, output int at);
    int k;
    @(posedge clock); #1;
    rd_seen = 0; wr_seen = 0;
    mem_word = mw;
    bus.pLsu_pReq_bWrEn = wr; bus.pLsu_pReq_bSize = sz; bus.pLsu_pReq_bUnsigned = u;
    bus.pLsu_pReq_bAddr = a;  bus.pLsu_pReq_bData = d;  bus.pLsu_pReq_bValid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.pLsu_pReq_bReady && k < 50);
    if (!bus.pLsu_pReq_bReady) chk("req_accept_timeout", 32'(bus.pLsu_pReq_bReady), 32'd1);
    @(posedge clock); #1;
    at = pcnt;
    bus.pLsu_pReq_bValid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic e, output int k);
    k = 0; d = 32'h0; e = 1'b0;
    forever begin
      @(negedge clock); k++;
      if (bus.pLsu_pResp_bValid) begin
        d = bus.pLsu_pResp_bData; e = bus.pLsu_pResp_bErr; break;
      end
      if (k >= 50) begin chk("resp_timeout", 32'(bus.pLsu_pResp_bValid), 32'd1); break; end
    end
  endtask

  task automatic run(input string nm, input logic wr, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] mw,
                     input logic [31:0] xd, input logic xe, input int xk, input int xrd, input int xwr);
    int at, k;
    logic [31:0] rd;
    logic re;
    issue(wr, sz, u, a, d, mw, at);
    wait_resp(rd, re, k);
    chk({nm, "_data"}, rd, xd);
    chk({nm, "_err"}, 32'(re), 32'(xe));
    chk({nm, "_lat"}, 32'(k), 32'(xk));
    chk({nm, "_rd_cycles"}, 32'(rd_seen), 32'(xrd));
    chk({nm, "_wr_cycles"}, 32'(wr_seen), 32'(xwr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int at0, at1, at2, k;
    logic [31:0] d0, dx;
    logic e0, ex;
    bus.pLsu_pReq_bValid = 1'b0; bus.pLsu_pReq_bWrEn = 1'b0; bus.pLsu_pReq_bSize = 2'd0;
    bus.pLsu_pReq_bUnsigned = 1'b0; bus.pLsu_pReq_bAddr = 32'h0; bus.pLsu_pReq_bData = 32'h0;
    bus.pLsu_pResp_bReady = 1'b1;
    #12;
    chk("rst_req_ready", 32'(bus.pLsu_pReq_bReady), 32'd1);
    chk("rst_resp_valid", 32'(bus.pLsu_pResp_bValid), 32'd0);
    chk("rst_rd_en", 32'(bus.pMemData_pRd_bEn), 32'd0);
    chk("rst_wr_en", 32'(bus.pMemData_pWr_bEn), 32'd0);
    chk("rst_resp_data", bus.pLsu_pResp_bData, 32'h0);
    chk("rst_rd_addr", bus.pMemData_pRd_bAddr, 32'h0);
    chk("rst_wr_data", bus.pMemData_pWr_bData, 32'h0);
    @(posedge clock); #1 reset = 1'b1;

    //   name     wr  sz    u  addr          wdata         mem           exp data     err k  rd wr
    run("lw",     0, 2'd2, 0, 32'h8000_0000, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2, 1, 0);
    run("lb",     0, 2'd0, 0, 32'h8000_0001, 32'h0,        32'h0000_00F0, 32'hFFFF_FFF0, 0, 2, 1, 0);
    run("lbu",    0, 2'd0, 1, 32'h8000_0001, 32'h0,        32'h0000_00F0, 32'h0000_00F0, 0, 2, 1, 0);
    run("lb_pos", 0, 2'd0, 0, 32'h8000_0003, 32'h0,        32'h1234_567F, 32'h0000_007F, 0, 2, 1, 0);
    run("lh",     0, 2'd1, 0, 32'h8000_0002, 32'h0,        32'h0000_8001, 32'hFFFF_8001, 0, 2, 1, 0);
    run("lhu",    0, 2'd1, 1, 32'h8000_0002, 32'h0,        32'h0000_8001, 32'h0000_8001, 0, 2, 1, 0);
    run("sh",     1, 2'd1, 0, 32'h8000_0010, 32'h1234_5678, 32'h0,        32'h0,         0, 2, 0, 1);
    chk("sh_mask", 32'(last_mask), 32'(4'b0011));
    chk("sh_wdata", last_wdata, 32'h1234_5678);
    run("sb",     1, 2'd0, 0, 32'h8000_0013, 32'h0000_00AB, 32'h0,        32'h0,         0, 2, 0, 1);
    chk("sb_mask", 32'(last_mask), 32'(4'b0001));
    run("sw",     1, 2'd2, 0, 32'h8000_0020, 32'hCAFE_F00D, 32'h0,        32'h0,         0, 2, 0, 1);
    chk("sw_mask", 32'(last_mask), 32'(4'b1111));
    run("lw_mis", 0, 2'd2, 0, 32'h8000_0002, 32'h0,        32'h1111_1111, 32'h0,         1, 1, 0, 0);
    run("lh_mis", 0, 2'd1, 1, 32'h8000_0005, 32'h0,        32'h2222_2222, 32'h0,         1, 1, 0, 0);
    run("sw_mis", 1, 2'd2, 0, 32'h8000_0021, 32'h5555_5555, 32'h0,        32'h0,         1, 1, 0, 0);
    run("sz_ill", 0, 2'd3, 0, 32'h8000_0000, 32'h0,        32'h3333_3333, 32'h0,         1, 1, 0, 0);

    // Response back-pressure: result must hold and no new request may be taken
    @(posedge clock); #1 bus.pLsu_pResp_bReady = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, at0);
    wait_resp(d0, e0, k);
    chk("bp_data", d0, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold_data", bus.pLsu_pResp_bData, 32'h0BAD_F00D);
      chk("bp_hold_valid", 32'(bus.pLsu_pResp_bValid), 32'd1);
      chk("bp_req_ready", 32'(bus.pLsu_pReq_bReady), 32'd0);
    end
    @(posedge clock); #1 bus.pLsu_pResp_bReady = 1'b1;

    // Back-to-back loads with the response side always ready
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0, 32'h0101_0101, at0);
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0105, 32'h0, 32'h0000_0088, at1);
    issue(1'b0, 2'd1, 1'b0, 32'h8000_010A, 32'h0, 32'h0000_7FFF, at2);
    wait_resp(dx, ex, k);
    chk("b2b_last_data", dx, 32'h0000_7FFF);
    chk("b2b_gap0", 32'(at1 - at0), 32'(LAT + 2));
    chk("b2b_gap1", 32'(at2 - at1), 32'(LAT + 2));

    // Reset while a load is reading memory
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0200, 32'h0, 32'h7777_7777, at0);
    chk("rd_before_rst", 32'(bus.pMemData_pRd_bEn), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rd_en", 32'(bus.pMemData_pRd_bEn), 32'd0);
    chk("rst_mid_resp_valid", 32'(bus.pLsu_pResp_bValid), 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", 32'(bus.pLsu_pReq_bReady), 32'd1);
    run("lw_after_rst", 0, 2'd2, 0, 32'h8000_0300, 32'h0, 32'h4242_4242, 32'h4242_4242, 0, 2, 1, 0);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
